// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - mode encodings, segment patterns and clamp limit shared by the FND display controller
package fnd_pkg;

    typedef enum logic [1:0] {
        MODE_STOPWATCH  = 2'b00,
        MODE_MICROWAVE  = 2'b01,
        MODE_AIR_HANDLE = 2'b10,
        MODE_BLANK      = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_LOAD,
        CONV_SHIFT,
        CONV_COMMIT
    } conv_state_t;

    localparam logic [6:0]  SEG_0       = 7'h40;
    localparam logic [6:0]  SEG_1       = 7'h79;
    localparam logic [6:0]  SEG_2       = 7'h24;
    localparam logic [6:0]  SEG_3       = 7'h30;
    localparam logic [6:0]  SEG_4       = 7'h19;
    localparam logic [6:0]  SEG_5       = 7'h12;
    localparam logic [6:0]  SEG_6       = 7'h02;
    localparam logic [6:0]  SEG_7       = 7'h78;
    localparam logic [6:0]  SEG_8       = 7'h00;
    localparam logic [6:0]  SEG_9       = 7'h10;
    localparam logic [6:0]  SEG_BLANK   = 7'h7F;
    localparam logic [13:0] CLAMP_LIMIT = 14'd9999;

    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/fnd_display_ctrl_bin2bcd_seq.sv
// rtl/fnd_display_ctrl_bin2bcd_seq.sv - free-running iterative double-dabble converter, 14-bit binary to 4-digit BCD
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] bin,
    output logic [15:0] bcd,
    output logic        valid
);

    conv_state_t conv_state;
    logic [15:0] bcd_work;
    logic [13:0] bin_work;
    logic [3:0]  iter;
    logic [29:0] shifted;

    function automatic logic [15:0] add3(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd5) ? v[i*4 +: 4] + 4'd3 : v[i*4 +: 4];
        end
        return r;
    endfunction

    always_comb begin
        shifted = {add3(bcd_work), bin_work} << 1;
    end

    // bcd only changes together with the valid pulse, so consumers never see a partial result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conv_state <= CONV_IDLE;
            bcd_work   <= '0;
            bin_work   <= '0;
            iter       <= '0;
            bcd        <= '0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (conv_state)
                CONV_IDLE: begin
                    conv_state <= CONV_LOAD;
                end
                CONV_LOAD: begin
                    bin_work   <= bin;
                    bcd_work   <= '0;
                    iter       <= '0;
                    conv_state <= CONV_SHIFT;
                end
                CONV_SHIFT: begin
                    {bcd_work, bin_work} <= shifted;
                    iter                 <= iter + 4'd1;
                    if (iter == 4'd13) begin
                        bcd        <= shifted[29:14];
                        valid      <= 1'b1;
                        conv_state <= CONV_COMMIT;
                    end
                end
                CONV_COMMIT: begin
                    conv_state <= CONV_LOAD;
                end
                default: begin
                    conv_state <= CONV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/fnd_display_ctrl.sv
// rtl/fnd_display_ctrl.sv - four-digit multiplexed FND controller; optional blinking under FND_BLINK_EN
module fnd_display_ctrl
    import fnd_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 100_000,
    parameter int unsigned BLINK_CYCLES   = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  state,
    input  logic [13:0] watch_seg_data,
    input  logic [13:0] oven_seg_data,
    input  logic [13:0] air_seg_data,
    input  logic [3:0]  dp_mask,
    input  logic        blink,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [13:0]      selected;
    logic [13:0]      clamped;
    logic [15:0]      bcd;
    logic             bcd_valid;
    logic [15:0]      disp_reg;
    logic [REF_W-1:0] refresh_cnt;
    logic [1:0]       idx;
    logic [3:0]       nibble;
    logic             blank_blink;
    logic             blank;

    always_comb begin
        selected = '0;
        case (mode_t'(state))
            MODE_STOPWATCH:  selected = watch_seg_data;
            MODE_MICROWAVE:  selected = oven_seg_data;
            MODE_AIR_HANDLE: selected = air_seg_data;
            default:         selected = '0;
        endcase
        clamped = (selected > CLAMP_LIMIT) ? CLAMP_LIMIT : selected;
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .bin   (clamped),
        .bcd   (bcd),
        .valid (bcd_valid)
    );

`ifdef FND_BLINK_EN
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    // dropping blink clears the phase so the next blink period starts visible
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!blink) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blank_blink = blink & blink_phase;
`else
    localparam int unsigned blink_cycles_unused = BLINK_CYCLES;
    logic blink_unused;

    assign blink_unused = blink;
    assign blank_blink  = 1'b0;
`endif

    assign nibble = disp_reg[{idx, 2'b00} +: 4];
    assign blank  = (mode_t'(state) == MODE_BLANK) | blank_blink;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            idx         <= '0;
            disp_reg    <= '0;
            an          <= 4'b1111;
            seg         <= 8'hFF;
        end else begin
            if (refresh_cnt == REF_W'(REFRESH_CYCLES - 1)) begin
                refresh_cnt <= '0;
                idx         <= idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            if (bcd_valid) begin
                disp_reg <= bcd;
            end
            an  <= blank ? 4'b1111 : ~(4'b0001 << idx);
            seg <= {~dp_mask[idx], seg_pattern(nibble)};
        end
    end

endmodule

// File: tb/tb_fnd_display_ctrl.sv
// tb/tb_fnd_display_ctrl.sv - randomized self-checking bench for fnd_display_ctrl against a decimal reference model
module tb_fnd_display_ctrl;

    localparam int RC = 4;
    localparam int BC = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  state;
    logic [13:0] watch_seg_data;
    logic [13:0] oven_seg_data;
    logic [13:0] air_seg_data;
    logic [3:0]  dp_mask;
    logic        blink;
    logic [3:0]  an;
    logic [7:0]  seg;

    int tests  = 0;
    int errors = 0;

    int pat[10]   = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int pow10[4]  = '{1, 10, 100, 1000};

    int          m_n    = 0;
    int          m_disp = 0;
    int          m_samp = 0;
    int          m_bc   = 0;
    logic [3:0]  exp_an  = 4'hF;
    logic [7:0]  exp_seg = 8'hFF;

    fnd_display_ctrl #(.REFRESH_CYCLES(RC), .BLINK_CYCLES(BC)) dut (
        .clk            (clk),
        .reset          (reset),
        .state          (state),
        .watch_seg_data (watch_seg_data),
        .oven_seg_data  (oven_seg_data),
        .air_seg_data   (air_seg_data),
        .dp_mask        (dp_mask),
        .blink          (blink),
        .an             (an),
        .seg            (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int selected_value(input logic [1:0] st);
        int v;
        case (st)
            2'd0:    v = int'(watch_seg_data);
            2'd1:    v = int'(oven_seg_data);
            2'd2:    v = int'(air_seg_data);
            default: v = 0;
        endcase
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic int decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (int'(p) == pat[i]) return i;
        return -1000;
    endfunction

    // Reference: digit d shown for RC cycles in turn; value sampled every 16 cycles starting on cycle 2
    always @(posedge clk) begin : model
        int  idx;
        int  dig;
        bit  blank;
        if (reset) begin
            m_n = 0; m_disp = 0; m_samp = 0; m_bc = 0;
            exp_an = 4'hF; exp_seg = 8'hFF;
        end else begin
            m_n++;
            idx   = ((m_n - 1) / RC) % 4;
            blank = (state == 2'b11);
`ifdef FND_BLINK_EN
            if (blink) begin
                if (((m_bc / BC) % 2) == 1) blank = 1'b1;
                m_bc++;
            end else begin
                m_bc = 0;
            end
`endif
            exp_an  = blank ? 4'hF : ~(4'b0001 << idx);
            dig     = (m_disp / pow10[idx]) % 10;
            exp_seg = {~dp_mask[idx], 7'(pat[dig])};
            if (m_n >= 2 && ((m_n - 2) % 16) == 0) m_samp = selected_value(state);
            if (m_n >= 17 && ((m_n - 17) % 16) == 0) m_disp = m_samp;
        end
    end

    always @(negedge clk) begin
        if (reset || m_n == 0) begin
            check("reset_an", 32'(an), 32'hF);
            check("reset_seg", 32'(seg), 32'hFF);
        end else begin
            check("an", 32'(an), 32'(exp_an));
            if (exp_an != 4'hF) check("seg", 32'(seg), 32'(exp_seg));
        end
    end

    // Reads one full 16-cycle display window aligned to a commit and returns the shown decimal value
    task automatic scan_value(output int v);
        int d[4];
        int guard;
        logic [3:0] sel_an;
        d = '{-1000, -1000, -1000, -1000};
        guard = 0;
        while ((m_n % 16) != 2 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) begin
                sel_an = ~(4'b0001 << i);
                if (an == sel_an) d[i] = decode(seg[6:0]);
            end
            if (k < 15) @(negedge clk);
        end
        v = d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
    endtask

    initial begin
        int v;
        int cnt;
        int guard;
        reset = 1'b1; state = 2'b00; watch_seg_data = 14'd345; oven_seg_data = '0;
        air_seg_data = '0; dp_mask = 4'b0000; blink = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;

        repeat (20) @(negedge clk);
        check("lit_d0_an", 32'(an), 32'b1110); check("lit_d0_seg", 32'(seg), 32'h92);
        @(negedge clk);
        check("lit_d1_an", 32'(an), 32'b1101); check("lit_d1_seg", 32'(seg), 32'h99);
        repeat (4) @(negedge clk);
        check("lit_d2_an", 32'(an), 32'b1011); check("lit_d2_seg", 32'(seg), 32'hB0);
        repeat (4) @(negedge clk);
        check("lit_d3_an", 32'(an), 32'b0111); check("lit_d3_seg", 32'(seg), 32'hC0);

        state = 2'b01; oven_seg_data = 14'd12000;
        repeat (40) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            check("clamp_seg", 32'(seg), 32'h90);
            @(negedge clk);
        end

        state = 2'b00; watch_seg_data = 14'd1234; dp_mask = 4'b0100;
        repeat (40) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            check("dp_bit", 32'(seg[7]), 32'(an != 4'b1011));
            @(negedge clk);
        end
        scan_value(v); check("scan_1234", 32'(v), 32'd1234);
        dp_mask = 4'b0000;

        state = 2'b01; oven_seg_data = 14'd100;
        repeat (40) @(negedge clk);
        guard = 0;
        while ((m_n % 16) != 5 && guard < 20) begin @(negedge clk); guard++; end
        oven_seg_data = 14'd230;
        scan_value(v); check("inflight_old", 32'(v), 32'd100);
        @(negedge clk);
        scan_value(v); check("inflight_new", 32'(v), 32'd230);

        state = 2'b00; blink = 1'b1;
        cnt = 0;
        for (int k = 0; k < BC; k++) begin @(negedge clk); if (an == 4'hF) cnt++; end
        check("blink_vis_half", 32'(cnt), 32'd0);
        cnt = 0;
        for (int k = 0; k < BC; k++) begin @(negedge clk); if (an == 4'hF) cnt++; end
`ifdef FND_BLINK_EN
        check("blink_dark_half", 32'(cnt), 32'd64);
`else
        check("blink_dark_half", 32'(cnt), 32'd0);
`endif
        blink = 1'b0;
        @(negedge clk);
        check("blink_off_scan", 32'(an != 4'hF), 32'd1);

        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 7) == 0) state = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) watch_seg_data = 14'($urandom_range(0, 16383));
            if ($urandom_range(0, 5) == 0) oven_seg_data  = 14'($urandom_range(0, 16383));
            if ($urandom_range(0, 5) == 0) air_seg_data   = 14'($urandom_range(0, 16383));
            if ($urandom_range(0, 9) == 0) dp_mask        = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 60) == 0) blink         = ~blink;
            @(negedge clk);
        end
        blink = 1'b0;

        state = 2'b00; @(negedge clk);
        state = 2'b11; @(negedge clk);
        check("blank_mode_an", 32'(an), 32'hF);

        state = 2'b00; watch_seg_data = 14'd7777;
        repeat (40) @(negedge clk);
        guard = 0;
        while ((m_n % 16) != 8 && guard < 20) begin @(negedge clk); guard++; end
        #2 reset = 1'b1;
        #1;
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_seg", 32'(seg), 32'hFF);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        scan_value(v); check("post_rst_zero", 32'(v), 32'd0);
        @(negedge clk);
        scan_value(v); check("post_rst_7777", 32'(v), 32'd7777);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
